// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline definitions: FSM encodings, control-bundle struct, drain default and perf width.
// The perf width is consumed only when PIPE_CTRL_PERF_EN is defined.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W        = 5;
  localparam int DRAIN_CYCLES_DEF = 3;
  localparam int PERF_W           = 32;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_FLOW = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  // The unused encoding 3 parks the core exactly like HALTED.
  function automatic logic is_halted_state(input logic [1:0] st);
    return (st == ST_HALTED) || (st == 2'd3);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Datapath <-> pipeline-controller signal bundle; master is the controller side.
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_IDX_W-1:0] id_rs1;
  logic [REG_IDX_W-1:0] id_rs2;
  logic                 id_uses_rs2;
  logic                 id_halt;
  logic [REG_IDX_W-1:0] ex_rd;
  logic                 ex_memread;
  logic                 ex_redirect;
  logic                 mem_busy;
  logic                 pc_en;
  logic                 ifid_en;
  logic                 idex_en;
  logic                 exmem_en;
  logic                 memwb_en;
  logic                 ifid_flush;
  logic                 idex_flush;
  logic                 halted;
  logic [1:0]           state;
`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0]    stall_cycles;
  logic [PERF_W-1:0]    flush_count;
`endif

  modport master (
    input  id_rs1, id_rs2, id_uses_rs2, id_halt, ex_rd, ex_memread, ex_redirect, mem_busy,
`ifdef PIPE_CTRL_PERF_EN
    output stall_cycles, flush_count,
`endif
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted, state
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs2, id_halt, ex_rd, ex_memread, ex_redirect, mem_busy,
`ifdef PIPE_CTRL_PERF_EN
    input  stall_cycles, flush_count,
`endif
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, halted, state
  );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the ID instruction.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs2_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic                 ex_memread_i,
  output logic                 load_use_o
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use_o = ex_memread_i && (ex_rd_i != {REG_IDX_W{1'b0}}) &&
                      ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall/flush/halt FSM with drain counter; outputs are combinational.
// Define PIPE_CTRL_PERF_EN to add the stall_cycles / flush_count performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input logic         clk,
  input logic         rst_n,
  pipe_ctrl_if.master bus
);

  localparam int CNT_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu_done_q, lu_done_d;
  logic             load_use_s;
  ctrl_t            ctrl_s;

  hazard_detect u_hazard (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_uses_rs2_i (bus.id_uses_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_memread_i  (bus.ex_memread),
    .load_use_o    (load_use_s)
  );

  // Next-state and control decode; lu_done_q limits each load-use stall to one cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lu_done_d = lu_done_q;
    ctrl_s    = CTRL_IDLE;
    if (!rst_n || bus.mem_busy) begin
      ctrl_s = CTRL_IDLE;
    end else begin
      case (state_q)
        ST_RUN: begin
          ctrl_s    = CTRL_FLOW;
          lu_done_d = 1'b0;
          if (bus.ex_redirect) begin
            ctrl_s.ifid_flush = 1'b1;
            ctrl_s.idex_flush = 1'b1;
          end else if (load_use_s && !lu_done_q) begin
            ctrl_s.pc_en      = 1'b0;
            ctrl_s.ifid_en    = 1'b0;
            ctrl_s.idex_flush = 1'b1;
            lu_done_d         = 1'b1;
          end else if (bus.id_halt) begin
            ctrl_s.pc_en      = 1'b0;
            ctrl_s.ifid_flush = 1'b1;
            cnt_d             = CNT_W'(DRAIN_CYCLES);
            state_d           = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
          end else begin
            ctrl_s = CTRL_FLOW;
          end
        end
        ST_DRAIN: begin
          ctrl_s         = CTRL_FLOW;
          ctrl_s.pc_en   = 1'b0;
          ctrl_s.ifid_en = 1'b0;
          cnt_d          = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          ctrl_s = CTRL_IDLE;
        end
      endcase
    end
  end

  // FSM, drain counter and stall-once flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      cnt_q     <= {CNT_W{1'b0}};
      lu_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lu_done_q <= lu_done_d;
    end
  end

  assign bus.pc_en      = ctrl_s.pc_en;
  assign bus.ifid_en    = ctrl_s.ifid_en;
  assign bus.idex_en    = ctrl_s.idex_en;
  assign bus.exmem_en   = ctrl_s.exmem_en;
  assign bus.memwb_en   = ctrl_s.memwb_en;
  assign bus.ifid_flush = ctrl_s.ifid_flush;
  assign bus.idex_flush = ctrl_s.idex_flush;
  assign bus.halted     = is_halted_state(state_q);
  assign bus.state      = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [PERF_W-1:0] stall_cycles_q;
  logic [PERF_W-1:0] flush_count_q;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= {PERF_W{1'b0}};
      flush_count_q  <= {PERF_W{1'b0}};
    end else begin
      if (!ctrl_s.pc_en && ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
        stall_cycles_q <= stall_cycles_q + PERF_W'(1);
      end else begin
        stall_cycles_q <= stall_cycles_q;
      end
      if (ctrl_s.ifid_flush) begin
        flush_count_q <= flush_count_q + PERF_W'(1);
      end else begin
        flush_count_q <= flush_count_q;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_q;
  assign bus.flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard/halt/reset scenarios plus randomized traffic.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int DC = 3;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs2;
    logic       halt;
    logic [4:0] rd;
    logic       memread;
    logic       redirect;
    logic       busy;
  } stim_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [9:0]  exp_q[$];

  int          m_state;
  int          m_left;
  bit          m_stalled;
  int unsigned m_stall_cnt;
  int unsigned m_flush_cnt;

  function automatic logic [9:0] dut_vec();
    return {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
            bus.ifid_flush, bus.idex_flush, bus.halted, bus.state};
  endfunction

  function automatic stim_t mk(input int rs1, input int rs2, input bit uses, input bit halt,
                               input int rd, input bit memread, input bit redirect, input bit busy);
    stim_t s;
    s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.uses_rs2 = uses; s.halt = halt;
    s.rd = 5'(rd); s.memread = memread; s.redirect = redirect; s.busy = busy;
    return s;
  endfunction

  // Reference behaviour: control bits {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}.
  function automatic logic [9:0] model_step(input stim_t s);
    bit       lu;
    bit [6:0] c;
    int       st_now;
    st_now = m_state;
    lu = s.memread && (s.rd != 5'd0) &&
         ((s.rd == s.rs1) || (s.uses_rs2 && (s.rd == s.rs2)));
    c = 7'b0000000;
    if (s.busy) begin
      c = 7'b0000000;
    end else if (m_state == 0) begin
      c = 7'b1111100;
      if (s.redirect) begin
        c[1:0] = 2'b11; m_stalled = 1'b0;
      end else if (lu && !m_stalled) begin
        c[6] = 1'b0; c[5] = 1'b0; c[0] = 1'b1; m_stalled = 1'b1;
      end else if (s.halt) begin
        c[6] = 1'b0; c[1] = 1'b1; m_stalled = 1'b0;
        m_left  = DC;
        m_state = (DC == 0) ? 2 : 1;
      end else begin
        m_stalled = 1'b0;
      end
    end else if (m_state == 1) begin
      c = 7'b0011100;
      m_left = m_left - 1;
      if (m_left == 0) m_state = 2;
    end
    if (!c[6] && st_now != 2) m_stall_cnt++;
    if (c[1]) m_flush_cnt++;
    return {c, (st_now == 2) ? 1'b1 : 1'b0, 2'(st_now)};
  endfunction

  task automatic drive(input stim_t s);
    bus.id_rs1 = s.rs1; bus.id_rs2 = s.rs2; bus.id_uses_rs2 = s.uses_rs2;
    bus.id_halt = s.halt; bus.ex_rd = s.rd; bus.ex_memread = s.memread;
    bus.ex_redirect = s.redirect; bus.mem_busy = s.busy;
  endtask

  task automatic cyc(input stim_t s);
    @(posedge clk);
    #1;
    drive(s);
    exp_q.push_back(model_step(s));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    drive('0);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (dut_vec() !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=%b", dut_vec(), 10'b0);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_tests++;
    if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_perf got=%0d/%0d exp=0/0", bus.stall_cycles, bus.flush_count);
    end
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_state = 0; m_left = 0; m_stalled = 1'b0; m_stall_cnt = 0; m_flush_cnt = 0;
  endtask

  // Monitor: one expectation per cycle, compared in the clock-low phase.
  initial begin
    logic [9:0] e;
    logic [9:0] a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_vec();
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL outputs t=%0t got=%b exp=%b", $time, a, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle;
    idle = '0;
    drive(idle);
    do_reset();

    // load-use stall, then the same inputs held, then x0 destination
    cyc(mk(5, 1, 0, 0, 5, 1, 0, 0));
    cyc(mk(5, 1, 0, 0, 5, 1, 0, 0));
    cyc(mk(0, 1, 0, 0, 0, 1, 0, 0));
    cyc(mk(2, 7, 1, 0, 7, 1, 0, 0));
    cyc(idle);

    // redirect overrides load-use and halt
    cyc(mk(5, 1, 0, 1, 5, 1, 1, 0));
    cyc(idle);

    // halt, drain, then stay halted
    cyc(mk(0, 0, 0, 1, 0, 0, 0, 0));
    repeat (13) cyc(idle);

    // halt with memory busy in the middle of drain
    do_reset();
    cyc(mk(0, 0, 0, 1, 0, 0, 0, 0));
    cyc(idle);
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1));
    cyc(mk(0, 0, 0, 0, 0, 0, 0, 1));
    repeat (5) cyc(idle);

    // halt blocked by a load-use on the same cycle
    do_reset();
    cyc(mk(3, 0, 0, 1, 3, 1, 0, 0));
    cyc(mk(3, 0, 0, 1, 3, 1, 0, 0));
    repeat (3) cyc(idle);

    // asynchronous reset mid-drain
    do_reset();
    cyc(mk(0, 0, 0, 1, 0, 0, 0, 0));
    cyc(idle);
    do_reset();
    repeat (2) cyc(idle);

    // perf scenario: 4 stalls, 2 redirects, halt
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(mk(i + 1, 0, 0, 0, i + 1, 1, 0, 0));
      cyc(idle);
    end
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0));
    cyc(mk(0, 0, 0, 0, 0, 0, 1, 0));
    cyc(mk(0, 0, 0, 1, 0, 0, 0, 0));
    repeat (6) cyc(idle);
    @(posedge clk);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    n_tests++;
    if (bus.stall_cycles !== 32'd8 || bus.stall_cycles !== 32'(m_stall_cnt)) begin
      n_fail++;
      $display("FAIL perf_stall got=%0d exp=8 model=%0d", bus.stall_cycles, m_stall_cnt);
    end
    n_tests++;
    if (bus.flush_count !== 32'd3 || bus.flush_count !== 32'(m_flush_cnt)) begin
      n_fail++;
      $display("FAIL perf_flush got=%0d exp=3 model=%0d", bus.flush_count, m_flush_cnt);
    end
`endif

    // randomized episodes
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int k = 0; k < 120; k++) begin
        stim_t s;
        s.rs1      = 5'($urandom_range(0, 3));
        s.rs2      = 5'($urandom_range(0, 3));
        s.rd       = 5'($urandom_range(0, 3));
        s.uses_rs2 = 1'($urandom_range(0, 1));
        s.memread  = 1'($urandom_range(0, 1));
        s.redirect = ($urandom_range(0, 99) < 15);
        s.busy     = ($urandom_range(0, 99) < 15);
        s.halt     = ($urandom_range(0, 99) < 4);
        cyc(s);
      end
`ifdef PIPE_CTRL_PERF_EN
      @(posedge clk);
      #1;
      n_tests++;
      if (bus.stall_cycles !== 32'(m_stall_cnt) || bus.flush_count !== 32'(m_flush_cnt)) begin
        n_fail++;
        $display("FAIL perf_random got=%0d/%0d exp=%0d/%0d", bus.stall_cycles, bus.flush_count,
                 m_stall_cnt, m_flush_cnt);
      end
`endif
    end

    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles needed after halt detection for the halt instruction to retire from WB.
REQ-002 Port clk, input, 1: sole clock, rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port id_rs1 / id_rs2, input, 5 each: source registers of the instruction in ID.
REQ-005 Port id_uses_rs2, input, 1: ID instruction reads rs2.
REQ-006 Port id_halt, input, 1: ID instruction is HALT.
REQ-007 Port ex_rd, input, 5, and ex_memread, input, 1: destination and load flag of the instruction in EX.
REQ-008 Port ex_redirect, input, 1: taken branch, JAL or JALR resolved in EX.
REQ-009 Port mem_busy, input, 1: data memory not ready this cycle.
REQ-010 Ports pc_en, ifid_en, idex_en, exmem_en, memwb_en, output, 1 each: PC and pipeline register load enables.
REQ-011 Ports ifid_flush and idex_flush, output, 1 each: load a bubble (all control bits 0) instead of data.
REQ-012 Port halted, output, 1: core stopped. Port state, output, 2: current FSM state.

Function
REQ-013 FSM states: RUN=0, DRAIN=1, HALTED=2. Encoding 3 is illegal and SHALL be treated as HALTED.
REQ-014 Outputs SHALL be combinational from state and inputs. Priority: mem_busy > ex_redirect > load-use > id_halt.
REQ-015 mem_busy=1 in any state: all enables 0, all flushes 0; state and drain counter hold.
REQ-016 RUN, no event: all enables 1, flushes 0.
REQ-017 RUN, ex_redirect=1: all enables 1, ifid_flush=1, idex_flush=1. A load-use or id_halt asserted in the same cycle SHALL be ignored because the ID instruction is wrong-path.
REQ-018 Load-use condition: ex_memread=1, ex_rd!=0, and either ex_rd==id_rs1 or (id_uses_rs2=1 and ex_rd==id_rs2).
REQ-019 RUN, load-use condition true: pc_en=0, ifid_en=0, idex_flush=1, other enables 1. The stall lasts exactly one cycle per occurrence.
REQ-020 RUN, id_halt=1 with no load-use condition: transition to DRAIN; load drain counter with DRAIN_CYCLES; pc_en=0, ifid_flush=1, other enables 1.
REQ-021 RUN, id_halt=1 with the load-use condition true: the load-use stall SHALL take effect first; halt is accepted on the following cycle.
REQ-022 DRAIN: pc_en=0, ifid_en=0, other enables 1, flushes 0. Each non-busy cycle decrements the counter. When the counter is 1 and the cycle is not busy, transition to HALTED.
REQ-023 DRAIN: ex_redirect and id_halt SHALL be ignored.
REQ-024 HALTED: all enables 0, flushes 0, halted=1. The only exit is reset.
REQ-025 Drain counter width SHALL be $clog2(DRAIN_CYCLES+1). DRAIN_CYCLES=0 SHALL transition directly from RUN to HALTED.

Reset
REQ-026 rst_n=0 SHALL immediately force the following, regardless of clk or any operation in progress (including DRAIN): state=RUN, counter=0, all enables 0, flushes 0, halted=0, and perf counters 0.
REQ-027 The first rising clk edge after rst_n deasserts SHALL produce RUN behaviour.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN, when defined, SHALL add the following outputs, each 32 bits and wrapping modulo 2^32:
- stall_cycles: increments on every cycle with pc_en=0 in RUN or DRAIN.
- flush_count: increments on every cycle with ifid_flush=1.
REQ-029 When PIPE_CTRL_PERF_EN is undefined, these ports and their registers SHALL be absent; all other behaviour is identical.

Structure
REQ-030 The state enum, DRAIN_CYCLES default and perf counter width SHALL live in the shared pipeline package alongside the stage register structs.
REQ-031 Hazard detection SHALL be a combinational sub-module hazard_detect (inputs: REQ-004, REQ-005, REQ-007; output: load_use). The FSM and counters stay in pipe_ctrl.

Verification
REQ-032 Load-use:
- Stimulus: ex_memread=1, ex_rd=5, id_rs1=5.
- Response: one cycle of pc_en=0, ifid_en=0, idex_flush=1; normal on the next cycle.
- Repeat with ex_rd=0: no stall.
REQ-033 Redirect with simultaneous load-use and id_halt:
- Stimulus: ex_redirect=1 together with a load-use condition and id_halt=1.
- Response: ifid_flush=1, idex_flush=1, pc_en=1; state stays RUN.
REQ-034 Halt:
- Stimulus: id_halt=1 in RUN, DRAIN_CYCLES=3.
- Response: state=DRAIN for exactly 3 cycles, then halted=1 and all enables 0 for the following 10 cycles.
REQ-035 Halt with memory stall:
- Stimulus: mem_busy=1 for 2 cycles in the middle of DRAIN.
- Response: all enables 0 during those cycles; HALTED reached 5 cycles after halt detection.
REQ-036 Reset mid-drain:
- Stimulus: rst_n=0 asynchronously during DRAIN.
- Response: state=0 and all outputs 0 before the next clk edge; RUN behaviour after release.
REQ-037 Perf counters (PIPE_CTRL_PERF_EN defined):
- Stimulus: 4 load-use stalls and 2 redirects, then a halt with DRAIN_CYCLES=3.
- Response: stall_cycles=4+1+3=8, flush_count=2+1=3.
